maxpool_2x2: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the combinational ReLU.
- Consumes one signed activation per accepted beat in raster order (row-major, one feature map at a time) and emits one pooled value per completed 2x2 window.
- Holds one row of horizontal pair-maxima in an internal line buffer.
- Provides valid/ready flow control on both sides so the conv/ReLU front end can be stalled by the output writer.

---
 rtl/maxpool_2x2_pkg.sv | 39 +++
 rtl/pool_linebuf.sv | 36 +++
 rtl/maxpool_2x2.sv | 137 +++++++++++++
 tb/tb_maxpool_2x2.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_2x2_pkg.sv
// ============================================================================
//  Module      : maxpool_2x2_pkg
//  Description : Shared types, default dimensions and width helpers for the
//                2x2 pooling stage. Optional feature macro: MAXPOOL_AVG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 8
`endif
`ifndef POOL_IMG_W
`define POOL_IMG_W 64
`endif
`ifndef POOL_IMG_H
`define POOL_IMG_H 64
`endif

package maxpool_2x2_pkg;

  typedef enum logic [0:0] {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Two guard bits let a 4-pixel sum be held without overflow.
`ifdef MAXPOOL_AVG_EN
  localparam int c_AVG_GUARD_BITS = 2;
`else
  localparam int c_AVG_GUARD_BITS = 0;
`endif

  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_linebuf.sv
// ============================================================================
//  Module      : pool_linebuf
//  Description : Single-port register array holding one row of horizontal
//                pair results; synchronous write, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_linebuf
  import maxpool_2x2_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = idx_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  // No reset: contents are always written on an even row before being read.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/maxpool_2x2.sv
// ============================================================================
//  Module      : maxpool_2x2
//  Description : Streaming 2x2 stride-2 max pooling with valid/ready on both
//                sides. Optional MAXPOOL_AVG_EN adds a pool_avg (sum>>2) mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_2x2
  import maxpool_2x2_pkg::*;
#(
  parameter int DATA_W = `INTERNAL_BITS,
  parameter int IMG_W  = `POOL_IMG_W,
  parameter int IMG_H  = `POOL_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef MAXPOOL_AVG_EN
  input  logic              pool_avg,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int SW       = DATA_W + c_AVG_GUARD_BITS;
  localparam int CW       = idx_bits(IMG_W);
  localparam int RW       = idx_bits(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = idx_bits(LB_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic signed [SW-1:0] r_hold;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic                 r_out_last;

  logic                 w_accept;
  logic                 w_lb_we;
  logic                 w_load;
  logic                 w_frame_end;
  logic [AW-1:0]        w_lb_addr;
  logic signed [SW-1:0] w_px;
  logic signed [SW-1:0] w_pair_max;
  logic signed [SW-1:0] w_pair;
  logic signed [SW-1:0] w_lb_rd;
  logic signed [SW-1:0] w_pool_max;
  logic signed [SW-1:0] w_pool;
  logic [DATA_W-1:0]    w_out;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_lb_addr   = AW'(r_col >> 1);
  assign w_lb_we     = w_accept && r_col[0] && !r_row[0];
  assign w_load      = w_accept && r_col[0] && r_row[0];
  assign w_frame_end = (r_col == COL_LAST) && (r_row == ROW_LAST);

  assign w_px       = SW'($signed(in_data));
  assign w_pair_max = (w_px > r_hold) ? w_px : r_hold;
  assign w_pool_max = (w_pair > w_lb_rd) ? w_pair : w_lb_rd;

`ifdef MAXPOOL_AVG_EN
  pool_mode_e           w_mode;
  logic signed [SW-1:0] w_avg;

  assign w_mode = pool_avg ? POOL_AVG : POOL_MAX;
  assign w_pair = (w_mode == POOL_AVG) ? (r_hold + w_px) : w_pair_max;
  assign w_pool = (w_mode == POOL_AVG) ? (w_lb_rd + w_pair) : w_pool_max;
  // Arithmetic shift gives floor division of the 4-pixel sum.
  assign w_avg  = w_pool >>> 2;
  assign w_out  = (w_mode == POOL_AVG) ? w_avg[DATA_W-1:0] : w_pool[DATA_W-1:0];
`else
  assign w_pair = w_pair_max;
  assign w_pool = w_pool_max;
  assign w_out  = w_pool[DATA_W-1:0];
`endif

  pool_linebuf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (SW),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (w_lb_addr),
    .i_wdata (w_pair),
    .o_rdata (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hold <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (!r_col[0]) begin
        r_hold <= w_px;
      end
    end
  end

  // A load wins over a drain so simultaneous load+drain keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out;
      r_out_last  <= w_frame_end;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2x2.sv
// ============================================================================
//  Module      : tb_maxpool_2x2
//  Description : Self-checking bench for maxpool_2x2 at a 4x4 image size.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_2x2;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef MAXPOOL_AVG_EN
  logic          pool_avg;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int got_d[$];
  bit got_l[$];
  int got_c[$];
  int exp_c[$];

  int basic_frame[NPIX] = '{1, -2, 3, 4, 5, 0, -7, 2, 9, 9, -1, -3, 0, 8, -5, -6};
  int basic_exp[NOUT]   = '{5, 4, 9, -1};

  maxpool_2x2 #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MAXPOOL_AVG_EN
    .pool_avg  (pool_avg),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_d.push_back(int'($signed(out_data)));
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
  end

  // Reference: max of each 2x2 window in raster order.
  function automatic int ref_pool(input int pix[NPIX], input int k);
    int r, c, m;
    r = 2 * (k / (W / 2));
    c = 2 * (k % (W / 2));
    m = pix[r * W + c];
    if (pix[r * W + c + 1] > m)   m = pix[r * W + c + 1];
    if (pix[(r + 1) * W + c] > m) m = pix[(r + 1) * W + c];
    if (pix[(r + 1) * W + c + 1] > m) m = pix[(r + 1) * W + c + 1];
    return m;
  endfunction

  task automatic clear_capture();
    got_d.delete();
    got_l.delete();
    got_c.delete();
    exp_c.delete();
  endtask

  task automatic send_pixel(input int v, input bit track);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 300);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL input_accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    if (track) exp_c.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int pix[NPIX], input bit idle);
    for (int i = 0; i < NPIX; i++) begin
      if (idle && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_pixel(pix[i], ((i / W) % 2 == 1) && (i % 2 == 1));
    end
  endtask

  task automatic wait_outputs(input int n, input int bound);
    int g;
    g = 0;
    while (got_d.size() < n && g < bound) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_capture();
    send_frame(basic_frame, 1'b0);
    wait_outputs(NOUT, 50);
    checks++;
    if (got_d.size() != NOUT) begin
      errors++; $display("FAIL basic_count: got %0d outputs, required %0d", got_d.size(), NOUT);
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        checks++;
        if (got_d[k] != basic_exp[k]) begin errors++; $display("FAIL basic_data[%0d]: got %0d, required %0d", k, got_d[k], basic_exp[k]); end
        checks++;
        if (got_l[k] != (k == NOUT - 1)) begin errors++; $display("FAIL basic_last[%0d]: got %0d, required %0d", k, got_l[k], (k == NOUT - 1)); end
        checks++;
        if (got_c[k] != exp_c[k]) begin errors++; $display("FAIL basic_latency[%0d]: output at cycle %0d, required %0d", k, got_c[k], exp_c[k]); end
      end
    end
  endtask

  task automatic test_negative();
    int pix[NPIX];
    int expv[NOUT] = '{-100, -100, -100, -1};
    for (int i = 0; i < NPIX; i++) pix[i] = -100;
    pix[3 * W + 3] = -1;
    clear_capture();
    send_frame(pix, 1'b0);
    wait_outputs(NOUT, 50);
    checks++;
    if (got_d.size() != NOUT) begin
      errors++; $display("FAIL negative_count: got %0d outputs, required %0d", got_d.size(), NOUT);
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        checks++;
        if (got_d[k] != expv[k]) begin errors++; $display("FAIL negative_data[%0d]: got %0d, required %0d", k, got_d[k], expv[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_capture();
    fork
      send_frame(basic_frame, 1'b0);
      begin
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
          checks++;
          if (out_data !== DW'(5)) begin errors++; $display("FAIL stall_out_data: got %0d, required 5", $signed(out_data)); end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(NOUT, 50);
    checks++;
    if (got_d.size() != NOUT) begin
      errors++; $display("FAIL stall_count: got %0d outputs, required %0d", got_d.size(), NOUT);
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        checks++;
        if (got_d[k] != basic_exp[k]) begin errors++; $display("FAIL stall_data[%0d]: got %0d, required %0d", k, got_d[k], basic_exp[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    send_frame(basic_frame, 1'b0);
    send_frame(basic_frame, 1'b0);
    wait_outputs(2 * NOUT, 80);
    checks++;
    if (got_d.size() != 2 * NOUT) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required %0d", got_d.size(), 2 * NOUT);
    end else begin
      for (int k = 0; k < 2 * NOUT; k++) begin
        checks++;
        if (got_d[k] != basic_exp[k % NOUT]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d, required %0d", k, got_d[k], basic_exp[k % NOUT]); end
        checks++;
        if (got_l[k] != (k % NOUT == NOUT - 1)) begin errors++; $display("FAIL b2b_last[%0d]: got %0d, required %0d", k, got_l[k], (k % NOUT == NOUT - 1)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_capture();
    for (int i = 0; i < 6; i++) send_pixel(basic_frame[i], 1'b0);
    reset = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    clear_capture();
    send_frame(basic_frame, 1'b0);
    wait_outputs(NOUT, 50);
    checks++;
    if (got_d.size() != NOUT) begin
      errors++; $display("FAIL midreset_count: got %0d outputs, required %0d", got_d.size(), NOUT);
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        checks++;
        if (got_d[k] != basic_exp[k]) begin errors++; $display("FAIL midreset_data[%0d]: got %0d, required %0d", k, got_d[k], basic_exp[k]); end
        checks++;
        if (got_l[k] != (k == NOUT - 1)) begin errors++; $display("FAIL midreset_last[%0d]: got %0d, required %0d", k, got_l[k], (k == NOUT - 1)); end
      end
    end
  endtask

  task automatic test_random();
    localparam int NF = 4;
    int frames[NF][NPIX];
    int expv[$];
    bit done;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < NPIX; i++) frames[f][i] = $urandom_range(0, 255) - 128;
      for (int k = 0; k < NOUT; k++) expv.push_back(ref_pool(frames[f], k));
    end
    clear_capture();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < NF; f++) send_frame(frames[f], 1'b1);
        wait_outputs(NF * NOUT, 600);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    checks++;
    if (got_d.size() != NF * NOUT) begin
      errors++; $display("FAIL random_count: got %0d outputs, required %0d", got_d.size(), NF * NOUT);
    end else begin
      for (int k = 0; k < NF * NOUT; k++) begin
        checks++;
        if (got_d[k] != expv[k]) begin errors++; $display("FAIL random_data[%0d]: got %0d, required %0d", k, got_d[k], expv[k]); end
        checks++;
        if (got_l[k] != (k % NOUT == NOUT - 1)) begin errors++; $display("FAIL random_last[%0d]: got %0d, required %0d", k, got_l[k], (k % NOUT == NOUT - 1)); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef MAXPOOL_AVG_EN
    pool_avg  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
